tx_ts_fifo: RTL and testbench

- Downstream consumer of the tx timestamp engine's timestamp interface in the rtc_clk domain.
- On txts_trig_i, captures the current RTC time. On the following txts_valid_i, pairs that time with the frame's PTP identity fields and pushes one entry into a small FIFO.
- Software or the register block pops entries through a show-ahead read port.
- Drives a level interrupt while entries are pending and flags overflow or orphaned triggers.

---
 rtl/tx_ts_fifo_pkg.sv | 22 ++
 rtl/tx_ts_fifo_sync_fifo_sa.sv | 72 +++++++
 rtl/tx_ts_fifo.sv | 150 +++++++++++++++
 tb/tb_tx_ts_fifo.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_ts_fifo_pkg.sv
// Shared types for the tx timestamp FIFO:
// entry layout and capture FSM states.
package tx_ts_fifo_pkg;

  localparam int TS_ENTRY_W = 184;

  // Field order from MSB to LSB:
  // time, portId, seqId, msgType, sdoId.
  typedef struct packed {
    logic [79:0] t;
    logic [79:0] port;
    logic [15:0] seq;
    logic [3:0]  msg;
    logic [3:0]  sdo;
  } ts_entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } cap_state_e;

endpackage

// File: rtl/tx_ts_fifo_sync_fifo_sa.sv
// Generic synchronous show-ahead FIFO with
// a registered head and a separate occupancy counter.
module sync_fifo_sa #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [W-1:0]  head_q, head_d;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = head_q;

  always_comb begin
    pop_ok   = pop_i & ~empty_o;
    push_ok  = push_i & (~full_o | pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok && !pop_ok)
      cnt_d = cnt_q + (AW+1)'(1);
    else if (pop_ok && !push_ok)
      cnt_d = cnt_q - (AW+1)'(1);
    // The word being written this cycle may
    // become the new head: bypass it.
    head_d = head_q;
    if (cnt_d != '0) begin
      if (push_ok && wr_ptr_q == rd_ptr_d)
        head_d = din_i;
      else
        head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/tx_ts_fifo.sv
// Pairs tx SFD timestamps with PTP identity
// fields and queues them for software readout.
module tx_ts_fifo
  import tx_ts_fifo_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int AW      = 2,
  parameter int TMO_CYC = 255
) (
  input  logic          rtc_clk,
  input  logic          rtc_rst,
  input  logic          enable_i,
  input  logic [79:0]   rtc_time_i,
  input  logic          txts_trig_i,
  input  logic          txts_valid_i,
  input  logic [79:0]   tx_sourcePortIdentity_i,
  input  logic [15:0]   tx_seqId_i,
  input  logic [3:0]    tx_messageType_i,
  input  logic [3:0]    tx_majorSdoId_i,
  input  logic          pop_i,
  input  logic          ovf_clr_i,
  output logic          ts_rdy_o,
  output logic [79:0]   ts_time_o,
  output logic [79:0]   ts_portId_o,
  output logic [15:0]   ts_seqId_o,
  output logic [3:0]    ts_msgType_o,
  output logic [3:0]    ts_sdoId_o,
  output logic [AW:0]   ts_count_o,
  output logic          ovf_o,
  output logic          orphan_o,
  output logic          int_txts_o
);

  if (DEPTH != (1 << AW) || DEPTH < 2) begin : g_bad_depth
    $error("DEPTH must equal 2**AW and be >= 2");
  end

  cap_state_e  state_q, state_d;
  logic [79:0] cap_time_q, cap_time_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        ovf_q, ovf_d;
  logic        orphan_q, orphan_d;
  logic        push, orphan_set, ovf_set;
  logic [79:0] push_time;
  logic        full, empty;
  ts_entry_t   push_entry, head;

  always_comb begin
    state_d    = state_q;
    cap_time_d = cap_time_q;
    tmo_d      = tmo_q;
    push       = 1'b0;
    push_time  = cap_time_q;
    orphan_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (txts_trig_i && enable_i) begin
          cap_time_d = rtc_time_i;
          if (txts_valid_i) begin
            push      = 1'b1;
            push_time = rtc_time_i;
          end else begin
            state_d = ST_WAIT;
          end
        end else if (txts_valid_i) begin
          orphan_set = 1'b1;
        end
      end
      ST_WAIT: begin
        tmo_d = tmo_q + 8'd1;
        if (!enable_i) begin
          state_d = ST_IDLE;
          tmo_d   = '0;
        end else if (txts_valid_i) begin
          push    = 1'b1;
          state_d = ST_IDLE;
          tmo_d   = '0;
        end else if (txts_trig_i) begin
          // Previous frame is lost; restart on the new SFD.
          cap_time_d = rtc_time_i;
          tmo_d      = '0;
          orphan_set = 1'b1;
        end else if ((tmo_q + 8'd1) == 8'(TMO_CYC)) begin
          state_d    = ST_IDLE;
          tmo_d      = '0;
          orphan_set = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tmo_d   = '0;
      end
    endcase

    ovf_set  = push & full & ~pop_i;
    ovf_d    = ovf_set | (ovf_q & ~ovf_clr_i);
    orphan_d = orphan_set | (orphan_q & ~ovf_clr_i);
  end

  always_comb begin
    push_entry.t    = push_time;
    push_entry.port = tx_sourcePortIdentity_i;
    push_entry.seq  = tx_seqId_i;
    push_entry.msg  = tx_messageType_i;
    push_entry.sdo  = tx_majorSdoId_i;
  end

  always_ff @(posedge rtc_clk) begin
    if (rtc_rst) begin
      state_q    <= ST_IDLE;
      cap_time_q <= '0;
      tmo_q      <= '0;
      ovf_q      <= 1'b0;
      orphan_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cap_time_q <= cap_time_d;
      tmo_q      <= tmo_d;
      ovf_q      <= ovf_d;
      orphan_q   <= orphan_d;
    end
  end

  sync_fifo_sa #(
    .W  (TS_ENTRY_W),
    .AW (AW)
  ) u_fifo (
    .clk     (rtc_clk),
    .rst     (rtc_rst),
    .push_i  (push),
    .din_i   (push_entry),
    .pop_i   (pop_i),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (ts_count_o)
  );

  assign ts_rdy_o     = ~empty;
  assign ts_time_o    = head.t;
  assign ts_portId_o  = head.port;
  assign ts_seqId_o   = head.seq;
  assign ts_msgType_o = head.msg;
  assign ts_sdoId_o   = head.sdo;
  assign ovf_o        = ovf_q;
  assign orphan_o     = orphan_q;
  assign int_txts_o   = ~empty & enable_i;

endmodule

// File: tb/tb_tx_ts_fifo.sv
// Self-checking bench for tx_ts_fifo: directed
// scenarios plus a randomized run against a queue model.
module tb_tx_ts_fifo;

  localparam int DEPTH = 4;
  localparam int TMO   = 255;

  logic        rtc_clk = 1'b0;
  logic        rtc_rst;
  logic        enable;
  logic [79:0] rtime;
  logic        trig, valid, pop, clr;
  logic [79:0] portid;
  logic [15:0] seq;
  logic [3:0]  msg, sdo;

  logic        ts_rdy_o;
  logic [79:0] ts_time_o, ts_portId_o;
  logic [15:0] ts_seqId_o;
  logic [3:0]  ts_msgType_o, ts_sdoId_o;
  logic [2:0]  ts_count_o;
  logic        ovf_o, orphan_o, int_txts_o;

  int nchk  = 0;
  int npass = 0;

  logic [183:0] mq[$];
  logic [183:0] mhead;
  bit           mpend;
  logic [79:0]  mptime;
  int           mage;
  bit           movf, morph;

  tx_ts_fifo dut (
    .rtc_clk                 (rtc_clk),
    .rtc_rst                 (rtc_rst),
    .enable_i                (enable),
    .rtc_time_i              (rtime),
    .txts_trig_i             (trig),
    .txts_valid_i            (valid),
    .tx_sourcePortIdentity_i (portid),
    .tx_seqId_i              (seq),
    .tx_messageType_i        (msg),
    .tx_majorSdoId_i         (sdo),
    .pop_i                   (pop),
    .ovf_clr_i               (clr),
    .ts_rdy_o                (ts_rdy_o),
    .ts_time_o               (ts_time_o),
    .ts_portId_o             (ts_portId_o),
    .ts_seqId_o              (ts_seqId_o),
    .ts_msgType_o            (ts_msgType_o),
    .ts_sdoId_o              (ts_sdoId_o),
    .ts_count_o              (ts_count_o),
    .ovf_o                   (ovf_o),
    .orphan_o                (orphan_o),
    .int_txts_o              (int_txts_o)
  );

  always #5 rtc_clk = ~rtc_clk;

  task automatic model_update();
    bit          do_push, oset, vset, did_pop;
    logic [79:0] et;
    do_push = 0; oset = 0; vset = 0; et = '0;
    if (rtc_rst) begin
      mq.delete();
      mhead = '0; mpend = 0; mage = 0;
      movf = 0; morph = 0; mptime = '0;
      return;
    end
    if (mpend) begin
      if (!enable) mpend = 0;
      else if (valid) begin
        do_push = 1; et = mptime; mpend = 0;
      end else if (trig) begin
        mptime = rtime; mage = 0; oset = 1;
      end else begin
        mage++;
        if (mage == TMO) begin
          mpend = 0; oset = 1;
        end
      end
    end else if (trig && enable) begin
      if (valid) begin
        do_push = 1; et = rtime;
      end else begin
        mpend = 1; mptime = rtime; mage = 0;
      end
    end else if (valid) begin
      oset = 1;
    end
    did_pop = pop && mq.size() > 0;
    if (did_pop) void'(mq.pop_front());
    if (do_push) begin
      if (mq.size() < DEPTH)
        mq.push_back({et, portid, seq, msg, sdo});
      else
        vset = 1;
    end
    movf  = vset | (movf & !clr);
    morph = oset | (morph & !clr);
    if (mq.size() > 0) mhead = mq[0];
  endtask

  task automatic step(input bit t, input bit v,
                      input bit p, input bit c);
    trig = t; valid = v; pop = p; clr = c;
    @(posedge rtc_clk);
    model_update();
    #1;
    trig = 0; valid = 0; pop = 0; clr = 0;
  endtask

  task automatic test_reset();
    rtc_rst = 1; enable = 1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rtc_rst = 0;
    nchk++;
    if ({ts_rdy_o, ts_count_o, ovf_o, orphan_o, int_txts_o} !== 7'd0)
      $display("FAIL reset_status got %b exp 0",
        {ts_rdy_o, ts_count_o, ovf_o, orphan_o, int_txts_o});
    else npass++;
    nchk++;
    if ({ts_time_o, ts_portId_o, ts_seqId_o, ts_msgType_o, ts_sdoId_o} !== 184'd0)
      $display("FAIL reset_head got %h exp 0", ts_time_o);
    else npass++;
  endtask

  task automatic test_basic();
    logic [79:0] pid;
    pid = {16'($urandom), $urandom, $urandom};
    rtime = 80'h000000000001_3B9AC9FF;
    step(1, 0, 0, 0);
    rtime = 80'h5;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    seq = 16'h0042; msg = 4'h0; sdo = 4'h3; portid = pid;
    step(0, 1, 0, 0);
    nchk++;
    if ({ts_rdy_o, ts_count_o, int_txts_o} !== 5'b1_001_1)
      $display("FAIL basic_status got %b exp 10011",
        {ts_rdy_o, ts_count_o, int_txts_o});
    else npass++;
    nchk++;
    if (ts_time_o !== 80'h000000000001_3B9AC9FF)
      $display("FAIL basic_time got %h exp 0000000000013b9ac9ff", ts_time_o);
    else npass++;
    nchk++;
    if ({ts_seqId_o, ts_msgType_o, ts_sdoId_o, ts_portId_o} !== {16'h0042, 4'h0, 4'h3, pid})
      $display("FAIL basic_ident got %h/%h exp 0042/%h", ts_seqId_o, ts_portId_o, pid);
    else npass++;
    step(0, 0, 1, 0);
    nchk++;
    if (ts_rdy_o !== 1'b0 || ts_seqId_o !== 16'h0042)
      $display("FAIL basic_pop_hold got rdy=%b seq=%h exp rdy=0 seq=0042",
        ts_rdy_o, ts_seqId_o);
    else npass++;
  endtask

  task automatic test_same_cycle();
    rtime = 80'h10; seq = 16'h0077;
    step(1, 1, 0, 0);
    nchk++;
    if (ts_time_o !== 80'h10 || ts_count_o !== 3'd1)
      $display("FAIL same_cycle got time=%h cnt=%0d exp time=10 cnt=1",
        ts_time_o, ts_count_o);
    else npass++;
    rtime = 80'h99;
    step(0, 1, 0, 0);
    nchk++;
    if (orphan_o !== 1'b1 || ts_count_o !== 3'd1)
      $display("FAIL lone_valid got orph=%b cnt=%0d exp orph=1 cnt=1",
        orphan_o, ts_count_o);
    else npass++;
    step(0, 0, 1, 1);
    nchk++;
    if (orphan_o !== 1'b0 || ts_count_o !== 3'd0)
      $display("FAIL orphan_clr got orph=%b cnt=%0d exp orph=0 cnt=0",
        orphan_o, ts_count_o);
    else npass++;
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) begin
      seq = 16'(i); rtime = 80'(i * 100);
      step(1, 1, 0, 0);
    end
    nchk++;
    if (ts_count_o !== 3'd4 || ovf_o !== 1'b1)
      $display("FAIL ovf_full got cnt=%0d ovf=%b exp cnt=4 ovf=1",
        ts_count_o, ovf_o);
    else npass++;
    for (int i = 1; i <= 4; i++) begin
      nchk++;
      if (ts_seqId_o !== 16'(i) || ts_time_o !== 80'(i * 100))
        $display("FAIL ovf_read got seq=%0d exp seq=%0d", ts_seqId_o, i);
      else npass++;
      step(0, 0, 1, 0);
    end
    nchk++;
    if (ts_rdy_o !== 1'b0 || ovf_o !== 1'b1)
      $display("FAIL ovf_drain got rdy=%b ovf=%b exp rdy=0 ovf=1",
        ts_rdy_o, ovf_o);
    else npass++;
    step(0, 0, 0, 1);
    nchk++;
    if (ovf_o !== 1'b0)
      $display("FAIL ovf_clr got %b exp 0", ovf_o);
    else npass++;
  endtask

  task automatic test_timeout();
    rtime = 80'hABC;
    step(1, 0, 0, 0);
    for (int i = 1; i < TMO; i++) step(0, 0, 0, 0);
    nchk++;
    if (orphan_o !== 1'b0)
      $display("FAIL tmo_early got %b exp 0", orphan_o);
    else npass++;
    step(0, 0, 0, 0);
    nchk++;
    if (orphan_o !== 1'b1)
      $display("FAIL tmo_fire got %b exp 1", orphan_o);
    else npass++;
    step(0, 1, 0, 0);
    nchk++;
    if (ts_count_o !== 3'd0)
      $display("FAIL tmo_late_valid got cnt=%0d exp 0", ts_count_o);
    else npass++;
    step(0, 0, 0, 1);
    nchk++;
    if (orphan_o !== 1'b0)
      $display("FAIL tmo_clr got %b exp 0", orphan_o);
    else npass++;
  endtask

  task automatic test_full_push_pop();
    for (int i = 10; i < 14; i++) begin
      seq = 16'(i); step(1, 1, 0, 0);
    end
    seq = 16'd14;
    step(1, 1, 1, 0);
    nchk++;
    if (ts_count_o !== 3'd4 || ts_seqId_o !== 16'd11 || ovf_o !== 1'b0)
      $display("FAIL full_pp got cnt=%0d seq=%0d ovf=%b exp 4/11/0",
        ts_count_o, ts_seqId_o, ovf_o);
    else npass++;
    for (int i = 11; i <= 14; i++) begin
      nchk++;
      if (ts_seqId_o !== 16'(i))
        $display("FAIL full_pp_drain got %0d exp %0d", ts_seqId_o, i);
      else npass++;
      step(0, 0, 1, 0);
    end
  endtask

  task automatic test_reset_mid_wait();
    seq = 16'h0055; rtime = 80'h1234;
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    rtc_rst = 1;
    step(0, 0, 0, 0);
    rtc_rst = 0;
    nchk++;
    if ({ts_rdy_o, ts_count_o, ovf_o, orphan_o, int_txts_o} !== 7'd0
        || ts_seqId_o !== 16'd0 || ts_time_o !== 80'd0)
      $display("FAIL rst_mid_wait got cnt=%0d orph=%b seq=%h exp all 0",
        ts_count_o, orphan_o, ts_seqId_o);
    else npass++;
    step(0, 1, 0, 0);
    nchk++;
    if (orphan_o !== 1'b1 || ts_count_o !== 3'd0)
      $display("FAIL rst_idle got orph=%b cnt=%0d exp 1/0",
        orphan_o, ts_count_o);
    else npass++;
    step(0, 0, 0, 1);
  endtask

  task automatic test_random();
    logic [6:0] exp_st;
    for (int n = 0; n < 3000; n++) begin
      enable  = ($urandom_range(0, 19) != 0);
      rtc_rst = ($urandom_range(0, 299) == 0);
      rtime   = {16'($urandom), $urandom, $urandom};
      portid  = {16'($urandom), $urandom, $urandom};
      seq     = 16'($urandom);
      msg     = 4'($urandom);
      sdo     = 4'($urandom);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
      exp_st = {mq.size() > 0, 3'(mq.size()), movf, morph,
                (mq.size() > 0) && enable};
      nchk++;
      if ({ts_rdy_o, ts_count_o, ovf_o, orphan_o, int_txts_o} !== exp_st)
        $display("FAIL rand_status n=%0d got %b exp %b", n,
          {ts_rdy_o, ts_count_o, ovf_o, orphan_o, int_txts_o}, exp_st);
      else npass++;
      nchk++;
      if ({ts_time_o, ts_portId_o, ts_seqId_o, ts_msgType_o, ts_sdoId_o} !== mhead)
        $display("FAIL rand_head n=%0d got seq=%h exp seq=%h", n,
          ts_seqId_o, mhead[23:8]);
      else npass++;
    end
    rtc_rst = 0;
  endtask

  initial begin
    rtc_rst = 1; enable = 1;
    trig = 0; valid = 0; pop = 0; clr = 0;
    rtime = '0; portid = '0; seq = '0; msg = '0; sdo = '0;
    mhead = '0; mpend = 0; mptime = '0; mage = 0;
    movf = 0; morph = 0;
    test_reset();
    test_basic();
    test_same_cycle();
    test_overflow();
    test_timeout();
    test_full_push_pop();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
